cop_wb_fifo: RTL and testbench
==============================

COP_WB_FIFO -- requirements
Module: cop_wb_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of result entries (power of 2, 2..8).
REQ-002 SHALL have port cop_clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port cop_rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port cop_wr  input  1  result-valid strobe from the ISE stage.
REQ-005 SHALL have port cop_insn  input  32  instruction of the current result; destination index is cop_insn[11:7].
REQ-006 SHALL have port cop_rd  input  32  result data from the ISE stage.
REQ-007 SHALL have port cop_rdywr  output  1  high when the FIFO can accept a result this cycle.
REQ-008 SHALL have port wb_valid  output  1  head entry is presented to the core register-file write port.
REQ-009 SHALL have port wb_ready  input  1  core accepts the head entry this cycle.
REQ-010 SHALL have port wb_addr  output  5  destination register of the head entry.
REQ-011 SHALL have port wb_data  output  32  data of the head entry.
REQ-012 SHALL have port wb_count  output  $clog2(DEPTH)+1  number of occupied entries.
REQ-013 SHALL have port hz_addr  input  5  source-register index probed by the core for RAW hazards.
REQ-014 SHALL have port hz_hit  output  1  hz_addr matches a pending entry.

Function
REQ-015 SHALL compute cop_rdywr = (wb_count != DEPTH), derived from registered state only; no dependence on wb_ready.
REQ-016 SHALL push {cop_insn[11:7], cop_rd} at write pointer when cop_wr && cop_rdywr && cop_insn[11:7] != 0.
REQ-017 SHALL accept and silently discard results with cop_insn[11:7] == 0; no entry used, count unchanged.
REQ-018 SHALL ignore cop_wr while cop_rdywr is low; no state change, no overwrite.
REQ-019 SHALL pop head entry when wb_valid && wb_ready.
REQ-020 SHALL drive wb_valid = (wb_count != 0); wb_addr/wb_data from head entry register, held stable while wb_valid && !wb_ready.
REQ-021 SHALL have push-to-wb_valid latency of exactly 1 cycle; no combinational bypass when empty.
REQ-022 SHALL deliver entries strictly in push order.
REQ-023 SHALL advance wr/rd pointers modulo DEPTH, wrapping from DEPTH-1 to 0.
REQ-024 SHALL, on simultaneous push and pop, keep wb_count unchanged and update both pointers.
REQ-025 SHALL, when full, refuse a push even if a pop occurs the same cycle (cop_rdywr low, REQ-015).
REQ-026 SHALL drive wb_addr = 0 and wb_data = 0 when wb_valid is low.
REQ-027 SHALL assert hz_hit combinationally when hz_addr != 0 and equals wb_addr of any occupied entry, including the head entry being popped this cycle.
REQ-028 SHALL NOT assert hz_hit for the incoming cop_wr result in the cycle it is pushed.

Reset
REQ-029 SHALL, while cop_rst is high at a clock edge, clear pointers and count to 0, overriding any concurrent push or pop.
REQ-030 SHALL present after reset: wb_valid=0, wb_count=0, cop_rdywr=1, wb_addr=0, wb_data=0, hz_hit=0.
REQ-031 SHALL discard all pending entries on reset mid-operation; no pending entry is written back afterwards.

Verification
REQ-032 Single push rd=5, data=0xDEADBEEF, wb_ready=1 -> next cycle wb_valid=1, wb_addr=5, wb_data=0xDEADBEEF; following cycle wb_count=0.
REQ-033 Five pushes rd=1..5 with wb_ready=0 (DEPTH=4) -> cop_rdywr=0 after 4th, 5th dropped; release wb_ready -> order 1,2,3,4 out.
REQ-034 Full FIFO, cop_wr=1 and wb_ready=1 same cycle -> pop only, wb_count 4->3, pushed data absent.
REQ-035 Push rd=0 data=0x12345678 -> wb_count stays 0, wb_valid stays 0, cop_rdywr stays 1.
REQ-036 Entries rd=7,9 pending, hz_addr=9 -> hz_hit=1; hz_addr=3 or 0 -> hz_hit=0; ten push/pop pairs -> pointers wrap, order preserved.
REQ-037 Three entries pending, cop_rst=1 for one cycle with wb_ready=1 -> wb_count=0, wb_valid=0, no further writebacks.

Source files
------------

// File: rtl/cop_wb_fifo.sv
// Coprocessor writeback FIFO: buffers ISE results and presents them in order to the
// core register-file write port, with a RAW-hazard probe over pending destinations.
module cop_wb_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     cop_clk,
  input  logic                     cop_rst,
  input  logic                     cop_wr,
  input  logic [31:0]              cop_insn,
  input  logic [31:0]              cop_rd,
  output logic                     cop_rdywr,
  output logic                     wb_valid,
  input  logic                     wb_ready,
  output logic [4:0]               wb_addr,
  output logic [31:0]              wb_data,
  output logic [$clog2(DEPTH):0]   wb_count,
  input  logic [4:0]               hz_addr,
  output logic                     hz_hit
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]    mem_addr_r [DEPTH];
  logic [31:0]   mem_data_r [DEPTH];
  logic [DEPTH-1:0] occ_r;
  logic [DEPTH-1:0] occ_next_s;
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_next_s;
  logic [4:0]    dst_s;
  logic          push_s;
  logic          pop_s;
  logic          hz_hit_s;
  logic          unused_insn_s;

  assign dst_s         = cop_insn[11:7];
  assign unused_insn_s = ^{cop_insn[31:12], cop_insn[6:0]};

  // Readiness and head presentation derive from registered state only
  assign cop_rdywr = (count_r != CW'(DEPTH));
  assign wb_valid  = (count_r != {CW{1'b0}});
  assign wb_count  = count_r;
  assign wb_addr   = wb_valid ? mem_addr_r[rd_ptr_r] : 5'd0;
  assign wb_data   = wb_valid ? mem_data_r[rd_ptr_r] : 32'd0;
  assign hz_hit    = hz_hit_s;

  // x0 destinations are accepted but never occupy an entry
  assign push_s = cop_wr && cop_rdywr && (dst_s != 5'd0);
  assign pop_s  = wb_valid && wb_ready;

  // Next occupancy map and entry count
  always_comb begin
    occ_next_s   = occ_r;
    count_next_s = count_r;
    if (pop_s) begin
      occ_next_s[rd_ptr_r] = 1'b0;
    end else begin
      occ_next_s[rd_ptr_r] = occ_r[rd_ptr_r];
    end
    if (push_s) begin
      occ_next_s[wr_ptr_r] = 1'b1;
    end else begin
      occ_next_s[wr_ptr_r] = occ_next_s[wr_ptr_r];
    end
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CW'(1);
      2'b01:   count_next_s = count_r - CW'(1);
      default: count_next_s = count_r;
    endcase
  end

  // Hazard probe over occupied entries only; the incoming result is not yet stored
  always_comb begin
    hz_hit_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (occ_r[i] && (mem_addr_r[i] == hz_addr) && (hz_addr != 5'd0)) begin
        hz_hit_s = 1'b1;
      end else begin
        hz_hit_s = hz_hit_s;
      end
    end
  end

  // Pointer, count and occupancy state; reset overrides any concurrent push or pop
  always_ff @(posedge cop_clk) begin
    if (cop_rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      occ_r    <= {DEPTH{1'b0}};
    end else begin
      occ_r   <= occ_next_s;
      count_r <= count_next_s;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
    end
  end

  // Entry storage; contents are only visible through occupied entries
  always_ff @(posedge cop_clk) begin
    if (!cop_rst && push_s) begin
      mem_addr_r[wr_ptr_r] <= dst_s;
      mem_data_r[wr_ptr_r] <= cop_rd;
    end
  end

endmodule

// File: tb/tb_cop_wb_fifo.sv
// Self-checking bench for cop_wb_fifo: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_cop_wb_fifo;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          cop_clk = 1'b0;
  logic          cop_rst;
  logic          cop_wr;
  logic [31:0]   cop_insn;
  logic [31:0]   cop_rd;
  logic          cop_rdywr;
  logic          wb_valid;
  logic          wb_ready;
  logic [4:0]    wb_addr;
  logic [31:0]   wb_data;
  logic [CW-1:0] wb_count;
  logic [4:0]    hz_addr;
  logic          hz_hit;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;
  ent_t q[$];

  cop_wb_fifo #(.DEPTH(DEPTH)) dut (
    .cop_clk(cop_clk), .cop_rst(cop_rst), .cop_wr(cop_wr), .cop_insn(cop_insn),
    .cop_rd(cop_rd), .cop_rdywr(cop_rdywr), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_addr(wb_addr), .wb_data(wb_data), .wb_count(wb_count), .hz_addr(hz_addr),
    .hz_hit(hz_hit)
  );

  always #5 cop_clk = ~cop_clk;

  // Expected observable state, derived purely from the model queue
  function automatic logic [4+32+CW+3:0] exp_vec(input logic [4:0] hz);
    logic hit;
    logic [4:0] a;
    logic [31:0] d;
    hit = 1'b0;
    foreach (q[i]) if (hz != 5'd0 && q[i].a == hz) hit = 1'b1;
    a = (q.size() != 0) ? q[0].a : 5'd0;
    d = (q.size() != 0) ? q[0].d : 32'd0;
    return {q.size() != 0, a, d, CW'(q.size()), q.size() != DEPTH, hit};
  endfunction

  function automatic logic [4+32+CW+3:0] dut_vec();
    return {wb_valid, wb_addr, wb_data, wb_count, cop_rdywr, hz_hit};
  endfunction

  task automatic drive(input logic wr, input logic [4:0] rd, input logic [31:0] data,
                       input logic ready, input logic [4:0] hz);
    cop_wr   = wr;
    cop_insn = {$urandom_range(0, 1048575), rd, 7'h0b};
    cop_rd   = data;
    wb_ready = ready;
    hz_addr  = hz;
    #1;
  endtask

  // Advance one clock, updating the model from the inputs sampled at the edge
  task automatic tick();
    logic do_push, do_pop;
    do_push = cop_wr && (q.size() < DEPTH) && (cop_insn[11:7] != 5'd0);
    do_pop  = (q.size() != 0) && wb_ready;
    @(posedge cop_clk);
    if (cop_rst) q.delete();
    else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back({cop_insn[11:7], cop_rd});
    end
    #1;
  endtask

  task automatic test_reset();
    cop_rst = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd5);
    tick();
    cop_rst = 1'b0;
    #1;
    checks++;
    if ({wb_valid, wb_count, cop_rdywr, wb_addr, wb_data, hz_hit} !== {1'b0, CW'(0), 1'b1, 5'd0, 32'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state got v=%b c=%0d r=%b a=%0d d=%h h=%b want v=0 c=0 r=1 a=0 d=0 h=0",
               wb_valid, wb_count, cop_rdywr, wb_addr, wb_data, hz_hit);
    end
  endtask

  task automatic test_single();
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd5);
    checks++;
    if (hz_hit !== 1'b0 || wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_no_bypass got hz=%b v=%b want hz=0 v=0", hz_hit, wb_valid);
    end
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5);
    checks++;
    if ({wb_valid, wb_addr, wb_data, hz_hit} !== {1'b1, 5'd5, 32'hDEADBEEF, 1'b1}) begin
      errors++;
      $display("FAIL single_head got v=%b a=%0d d=%h hz=%b want v=1 a=5 d=deadbeef hz=1",
               wb_valid, wb_addr, wb_data, hz_hit);
    end
    tick();
    checks++;
    if (wb_count !== CW'(0) || wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_drain got c=%0d v=%b want c=0 v=0", wb_count, wb_valid);
    end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 5'(i), 32'h100 + 32'(i), 1'b0, 5'd0);
      tick();
      if (i == 4) begin
        checks++;
        if (cop_rdywr !== 1'b0 || wb_count !== CW'(4)) begin
          errors++;
          $display("FAIL fill_full got r=%b c=%0d want r=0 c=4", cop_rdywr, wb_count);
        end
      end
    end
    checks++;
    if (wb_count !== CW'(4)) begin
      errors++;
      $display("FAIL fill_drop5 got c=%0d want c=4", wb_count);
    end
    for (int i = 1; i <= 4; i++) begin
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0);
      checks++;
      if (wb_valid !== 1'b1 || wb_addr !== 5'(i) || wb_data !== 32'h100 + 32'(i)) begin
        errors++;
        $display("FAIL fill_order got v=%b a=%0d d=%h want v=1 a=%0d d=%h",
                 wb_valid, wb_addr, wb_data, i, 32'h100 + 32'(i));
      end
      tick();
    end
    checks++;
    if (wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL fill_empty got v=%b want v=0", wb_valid);
    end
  endtask

  task automatic test_full_pushpop();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5'(10 + i), 32'hA0 + 32'(i), 1'b0, 5'd0);
      tick();
    end
    drive(1'b1, 5'd20, 32'hBAD, 1'b1, 5'd20);
    checks++;
    if (hz_hit !== 1'b0) begin
      errors++;
      $display("FAIL full_hz_incoming got hz=%b want 0", hz_hit);
    end
    tick();
    checks++;
    if (wb_count !== CW'(3)) begin
      errors++;
      $display("FAIL full_pushpop_count got c=%0d want c=3", wb_count);
    end
    for (int i = 1; i < 4; i++) begin
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd20);
      checks++;
      if (wb_addr !== 5'(10 + i) || hz_hit !== 1'b0) begin
        errors++;
        $display("FAIL full_pushpop_order got a=%0d hz=%b want a=%0d hz=0", wb_addr, hz_hit, 10 + i);
      end
      tick();
    end
  endtask

  task automatic test_zero_rd();
    drive(1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    checks++;
    if ({wb_count, wb_valid, cop_rdywr} !== {CW'(0), 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL zero_rd got c=%0d v=%b r=%b want c=0 v=0 r=1", wb_count, wb_valid, cop_rdywr);
    end
  endtask

  task automatic test_hazard();
    logic [4:0] probes [4];
    logic       want   [4];
    probes = '{5'd9, 5'd3, 5'd0, 5'd7};
    want   = '{1'b1, 1'b0, 1'b0, 1'b1};
    drive(1'b1, 5'd7, 32'h7, 1'b0, 5'd0); tick();
    drive(1'b1, 5'd9, 32'h9, 1'b0, 5'd0); tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 5'd0, 32'd0, 1'b0, probes[i]);
      checks++;
      if (hz_hit !== want[i]) begin
        errors++;
        $display("FAIL hazard_probe hz_addr=%0d got %b want %b", probes[i], hz_hit, want[i]);
      end
    end
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
    checks++;
    if (hz_hit !== 1'b1) begin
      errors++;
      $display("FAIL hazard_popping_head got %b want 1", hz_hit);
    end
    tick();
    tick();
  endtask

  task automatic test_wrap();
    drive(1'b1, 5'd1, 32'hC00, 1'b0, 5'd0);
    tick();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 5'(2 + i), 32'hC01 + 32'(i), 1'b1, 5'(2 + i));
      checks++;
      if (dut_vec() !== exp_vec(hz_addr) || wb_addr !== 5'(1 + i)) begin
        errors++;
        $display("FAIL wrap_pair%0d got %h want %h", i, dut_vec(), exp_vec(hz_addr));
      end
      tick();
    end
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0);
    tick();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'(3 + i), 32'(i), 1'b0, 5'd0);
      tick();
    end
    cop_rst = 1'b1;
    drive(1'b1, 5'd9, 32'h99, 1'b1, 5'd0);
    tick();
    cop_rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd3);
      checks++;
      if ({wb_count, wb_valid, hz_hit} !== {CW'(0), 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL reset_mid cyc%0d got c=%0d v=%b hz=%b want c=0 v=0 hz=0",
                 i, wb_count, wb_valid, hz_hit);
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cop_rst = ($urandom_range(0, 63) == 0);
      drive($urandom_range(0, 2) != 0, ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
            $urandom(), $urandom_range(0, 2) == 0, 5'($urandom_range(0, 31)));
      if (q.size() != 0 && $urandom_range(0, 1) == 1) hz_addr = q[$urandom_range(0, q.size() - 1)].a;
      #1;
      checks++;
      if (dut_vec() !== exp_vec(hz_addr)) begin
        errors++;
        $display("FAIL random cyc%0d got %h want %h", i, dut_vec(), exp_vec(hz_addr));
      end
      tick();
    end
    cop_rst = 1'b0;
  endtask

  initial begin
    cop_rst = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    test_reset();
    test_single();
    test_fill();
    test_full_pushpop();
    test_zero_rd();
    test_hazard();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
